md_stall_ctrl: RTL and testbench

- Sequencer and hazard controller for the multi-cycle multiply/divide unit (MDU) and its HI/LO resource.
- Sits beside the bypass selectors in the hazard logic and watches the instructions in D and E.
- Issues a start pulse to the MDU when mult/div reaches E, and counts the busy period.
- Stalls D while any HI/LO-class instruction would collide with an in-flight operation.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/md_decode.sv | 33 +++
 rtl/md_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_md_stall_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the MDU hazard/sequencing logic.
//   - funct codes of the eight HI/LO-class R-type instructions
//   - md_op encodings presented to the MDU
//   - sequencer state enum
//   - default MDU latencies and counter width
package hazard_pkg;

   localparam logic [5:0] OPC_SPECIAL = 6'h00;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int DEF_MULT_LAT = 5;
   localparam int DEF_DIV_LAT  = 10;
   localparam int DEF_CNT_W    = 4;

   // div/divu are distinguished from mult/multu by op bit 1
   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/md_decode.sv
// Combinational classifier for one pipeline-stage instruction.
// Ports:
//   instr     in  32  instruction word
//   is_start  out 1   mult/multu/div/divu (starts the MDU)
//   is_hilo   out 1   any instruction touching HI/LO (start-class + mf/mt hi/lo)
//   op        out 2   funct[1:0], the md_op encoding for start-class codes
module md_decode
   import hazard_pkg::*;
(
   input  logic [31:0] instr,
   output logic        is_start,
   output logic        is_hilo,
   output logic [1:0]  op
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       special;
   logic       unused_fields;

   assign opcode        = instr[31:26];
   assign funct         = instr[5:0];
   assign special       = (opcode == OPC_SPECIAL);
   assign unused_fields = ^instr[25:6];

   always_comb begin
      is_start = special && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
      is_hilo  = special && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                                           FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
      op       = funct[1:0];
   end

endmodule

// File: rtl/md_stall_ctrl.sv
// MDU sequencer and HI/LO hazard controller.
// Watches D and E; fires a start pulse when mult/div reaches E, counts the
// MDU busy period, and stalls D while a HI/LO-class instruction would
// collide with an in-flight operation.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | MDU free; a valid start-class instruction in E starts it
// ST_BUSY | MDU running; busy_cnt = remaining busy cycles (1 = last)
//
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   instrD    in  32     instruction in decode
//   instrE    in  32     instruction in execute
//   e_valid   in  1      E holds a real instruction
//   md_start  out 1      one-cycle MDU start pulse
//   md_op     out 2      operation, valid with md_start, else 0
//   md_busy   out 1      MDU occupied this cycle (LAT cycles per op)
//   md_done   out 1      last busy cycle; HI/LO written at the next edge
//   stall_md  out 1      freeze PC and IF/ID, bubble into ID/EX
//   busy_cnt  out CNT_W  remaining BUSY cycles
//
// MULT_LAT and DIV_LAT must be >= 2, and 2**CNT_W > max(MULT_LAT, DIV_LAT).
module md_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int DIV_LAT  = DEF_DIV_LAT,
   parameter int CNT_W    = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      instrD,
   input  logic [31:0]      instrE,
   input  logic             e_valid,
   output logic             md_start,
   output logic [1:0]       md_op,
   output logic             md_busy,
   output logic             md_done,
   output logic             stall_md,
   output logic [CNT_W-1:0] busy_cnt
);

   // The start cycle itself is one of the LAT cycles, so BUSY lasts LAT-1.
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

   md_state_e        st;
   md_state_e        st_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   logic       start_e;
   logic       hilo_e_unused;
   logic [1:0] op_e;
   logic       start_d_unused;
   logic       hilo_d;
   logic [1:0] op_d_unused;

   md_decode u_dec_e (
      .instr    (instrE),
      .is_start (start_e),
      .is_hilo  (hilo_e_unused),
      .op       (op_e)
   );

   md_decode u_dec_d (
      .instr    (instrD),
      .is_start (start_d_unused),
      .is_hilo  (hilo_d),
      .op       (op_d_unused)
   );

   // rst_n gates md_start directly so the combinational outputs are quiet
   // during reset even while E presents a valid mult/div.
   always_comb begin
      md_start = rst_n & e_valid & start_e & (st == ST_IDLE);
      md_op    = md_start ? op_e : 2'b00;
      md_busy  = md_start | (st == ST_BUSY);
      md_done  = (st == ST_BUSY) && (busy_cnt == CNT_ONE);
      // md_busy includes md_start so a mult/div in D is held back in the
      // very cycle its predecessor starts.
      stall_md = hilo_d & md_busy;
   end

   always_comb begin
      st_nxt  = st;
      cnt_nxt = busy_cnt;
      case (st)
         ST_IDLE: begin
            if (md_start) begin
               st_nxt  = ST_BUSY;
               cnt_nxt = op_is_div(op_e) ? DIV_LOAD : MULT_LOAD;
            end
         end
         ST_BUSY: begin
            // A start-class instruction in E here is ignored; the
            // countdown proceeds untouched.
            if (busy_cnt > CNT_ONE) begin
               cnt_nxt = busy_cnt - CNT_ONE;
            end else begin
               st_nxt  = ST_IDLE;
               cnt_nxt = CNT_ZERO;
            end
         end
         default: begin
            st_nxt  = ST_IDLE;
            cnt_nxt = CNT_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= ST_IDLE;
         busy_cnt <= CNT_ZERO;
      end else begin
         st       <= st_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl. The driver applies one input vector per
// cycle and queues the hand-computed outputs for that cycle; an independent
// monitor samples the DUT on the falling edge and checks against the queue.
module tb_md_stall_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] ADD   = 32'h0043_0820;
   localparam logic [31:0] MULT  = 32'h0043_0018;
   localparam logic [31:0] MULTU = 32'h0043_0019;
   localparam logic [31:0] DIV   = 32'h0043_001A;
   localparam logic [31:0] DIVU  = 32'h0043_001B;
   localparam logic [31:0] MFHI  = 32'h0000_2010;
   localparam logic [31:0] MFLO  = 32'h0000_2012;
   localparam logic [31:0] MTHI  = 32'h0040_0011;
   localparam logic [31:0] MTLO  = 32'h0040_0013;
   localparam logic [31:0] LWX   = 32'h8C43_0018;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instrD = ADD;
   logic [31:0] instrE = MULT;
   logic        e_valid = 1'b1;
   logic        md_start;
   logic [1:0]  md_op;
   logic        md_busy;
   logic        md_done;
   logic        stall_md;
   logic [3:0]  busy_cnt;

   int checks = 0;
   int errors = 0;
   logic drain_timeout = 1'b0;

   logic [9:0] exp_q[$];
   string      name_q[$];

   md_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .instrD   (instrD),
      .instrE   (instrE),
      .e_valid  (e_valid),
      .md_start (md_start),
      .md_op    (md_op),
      .md_busy  (md_busy),
      .md_done  (md_done),
      .stall_md (stall_md),
      .busy_cnt (busy_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] ex(input logic s, input logic [1:0] op,
                                     input logic b, input logic dn,
                                     input logic stl, input int c);
      return {s, op, b, dn, stl, 4'(c)};
   endfunction

   task automatic cyc(input string nm, input logic r, input logic [31:0] d,
                      input logic [31:0] e, input logic v, input logic [9:0] x);
      @(posedge clk);
      #1;
      rst_n   = r;
      instrD  = d;
      instrE  = e;
      e_valid = v;
      exp_q.push_back(x);
      name_q.push_back(nm);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [9:0] act;
      logic [9:0] want;
      string      nm;
      act = {md_start, md_op, md_busy, md_done, stall_md, busy_cnt};
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         nm   = name_q.pop_front();
         checks++;
         if (act !== want) begin
            errors++;
            $display("FAIL %s @%0t: got start=%0b op=%0d busy=%0b done=%0b stall=%0b cnt=%0d, expected start=%0b op=%0d busy=%0b done=%0b stall=%0b cnt=%0d",
                     nm, $time, act[9], act[8:7], act[6], act[5], act[4], act[3:0],
                     want[9], want[8:7], want[6], want[5], want[4], want[3:0]);
         end
      end
      if (drain_timeout) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
         drain_timeout <= 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset holds everything low even with a valid mult in E
      cyc("rst_hold",    0, ADD, MULT, 1, ex(0,0,0,0,0,0));
      cyc("rst_hold",    0, ADD, MULT, 1, ex(0,0,0,0,0,0));
      cyc("rst_release", 1, ADD, MULT, 1, ex(1,0,1,0,0,0));
      for (int c = 4; c >= 1; c--)
         cyc("mult_busy", 1, ADD, ADD, 1, ex(0,0,1,(c==1),0,c));
      cyc("mult_idle",   1, ADD, ADD, 1, ex(0,0,0,0,0,0));

      // div with mflo waiting in D
      cyc("div_start",   1, MFLO, DIV, 1, ex(1,2,1,0,1,0));
      for (int c = 9; c >= 1; c--)
         cyc("div_stall", 1, MFLO, NOP, 0, ex(0,0,1,(c==1),1,c));
      cyc("mflo_issue",  1, MFLO, NOP, 0, ex(0,0,0,0,0,0));

      // back-to-back: multu in D behind mult in E; starts 6 cycles apart
      cyc("b2b_start1",  1, MULTU, MULT, 1, ex(1,0,1,0,1,0));
      for (int c = 4; c >= 1; c--)
         cyc("b2b_stall", 1, MULTU, NOP, 0, ex(0,0,1,(c==1),1,c));
      cyc("b2b_release", 1, MULTU, NOP, 0, ex(0,0,0,0,0,0));
      cyc("b2b_start2",  1, ADD, MULTU, 1, ex(1,1,1,0,0,0));
      for (int c = 4; c >= 1; c--)
         cyc("b2b_busy", 1, ADD, ADD, 1, ex(0,0,1,(c==1),0,c));

      // bubbles and non-SPECIAL opcodes never start
      cyc("bubble_mult", 1, ADD, MULT, 0, ex(0,0,0,0,0,0));
      cyc("nonspecial",  1, LWX, LWX, 1, ex(0,0,0,0,0,0));

      // start-class in E while busy is ignored; mthi/mtlo stall, lw doesn't
      cyc("divu_start",   1, ADD,  DIVU, 1, ex(1,3,1,0,0,0));
      cyc("illegal_div",  1, MTHI, DIV,  1, ex(0,0,1,0,1,9));
      cyc("illegal_mult", 1, MTLO, MULT, 1, ex(0,0,1,0,1,8));
      cyc("busy_lw_d",    1, LWX,  ADD,  1, ex(0,0,1,0,0,7));
      for (int c = 6; c >= 1; c--)
         cyc("divu_busy", 1, ADD, ADD, 1, ex(0,0,1,(c==1),0,c));
      cyc("divu_idle",    1, ADD, ADD, 1, ex(0,0,0,0,0,0));

      // reset in the middle of a div, at busy_cnt = 6
      cyc("div2_start",   1, ADD, DIV, 1, ex(1,2,1,0,0,0));
      for (int c = 9; c >= 7; c--)
         cyc("div2_busy", 1, ADD, ADD, 1, ex(0,0,1,0,0,c));
      cyc("midop_rst",      0, MFHI, DIV, 1, ex(0,0,0,0,0,0));
      cyc("midop_rst_hold", 0, MFHI, DIV, 1, ex(0,0,0,0,0,0));
      cyc("post_rst_mult",  1, MFHI, MULT, 1, ex(1,0,1,0,1,0));
      for (int c = 4; c >= 1; c--)
         cyc("mfhi_stall", 1, MFHI, NOP, 0, ex(0,0,1,(c==1),1,c));
      cyc("mfhi_issue",     1, MFHI, NOP, 0, ex(0,0,0,0,0,0));

      for (int i = 0; i < 5 && exp_q.size() > 0; i++)
         @(posedge clk);
      if (exp_q.size() > 0) begin
         drain_timeout = 1'b1;
      end
      @(posedge clk);
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
